// File: rtl/ext_ins_server.sv
// ext_ins_server: upstream source for the core's external-instruction port.
//
// Read requests (exIns_ren/exIns_addr) are queued in a DEPTH-entry FIFO and
// served one at a time. Each good request waits WAIT_STATES idle cycles, then
// reads one word from a synchronous backing memory (data one cycle after
// mem_en). Misaligned or out-of-range requests get a NOP (addi x0,x0,0) with
// exIns_err set, and the memory is not touched.
//
// Ports:
//   clk, nrst            clock (rising edge), asynchronous active-low reset
//   exIns_ren/addr       request strobe and byte address from the core
//   exIns_valid/in/err   one-cycle response pulse, data word, bad-request flag
//   mem_en/addr/rdata    synchronous backing memory read port (word address)
//   busy                 FSM not idle or requests still queued
//   overflow             sticky: a request arrived while the FIFO was full
module ext_ins_server #(
  parameter int DEPTH       = 4,
  parameter int WAIT_STATES = 2,
  parameter int MEM_WORDS   = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          exIns_ren,
  input  logic [31:0]   exIns_addr,
  output logic          exIns_valid,
  output logic [31:0]   exIns_in,
  output logic          exIns_err,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  output logic          busy,
  output logic          overflow
);

  localparam int          PW        = $clog2(DEPTH);
  localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_ERR} state_t;

  logic [31:0]   r_fifo [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_cur_word;
  logic          r_overflow;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [31:0]   w_head;
  logic          w_bad;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (PW+1)'(DEPTH));
  assign w_head  = r_fifo[r_rd_ptr];
  assign w_bad   = (w_head[1:0] != 2'b00) || (w_head[31:2] >= MEM_LIMIT);

  // The cycle a response is presented is a turnaround cycle: no pop then, so
  // back-to-back responses are 4+WAIT_STATES apart (3 for bad requests).
  assign w_pop  = (r_state == S_IDLE) && !w_empty && !exIns_valid;
  // A full FIFO still accepts a request when an entry leaves in the same cycle.
  assign w_push = exIns_ren && (!w_full || w_pop);

  assign busy     = (r_state != S_IDLE) || !w_empty;
  assign overflow = r_overflow;

  // NOTE: always_comb outputs get a default first so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    mem_en   = 1'b0;
    mem_addr = '0;
    if (r_state == S_WAIT && r_cnt == 4'd0) begin
      mem_en   = 1'b1;
      mem_addr = r_cur_word;
    end
  end

  // NOTE: FIFO storage has no reset; occupancy is tracked by the pointers and
  // count, so stale entries are never read and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= exIns_addr;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_cur_word  <= '0;
      exIns_valid <= 1'b0;
      exIns_in    <= 32'h0;
      exIns_err   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (exIns_ren && !w_push) r_overflow <= 1'b1;

      exIns_valid <= 1'b0;
      exIns_err   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cur_word <= w_head[AW+1:2];
            if (w_bad) begin
              r_state <= S_ERR;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT_STATES);
            end
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) r_cnt   <= r_cnt - 4'd1;
          else               r_state <= S_READ;
        end
        S_READ: begin
          exIns_in    <= mem_rdata;
          exIns_valid <= 1'b1;
          r_state     <= S_IDLE;
        end
        S_ERR: begin
          exIns_in    <= NOP;
          exIns_valid <= 1'b1;
          exIns_err   <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_ins_server.sv
module tb_ext_ins_server;

  localparam int DEPTH     = 4;
  localparam int WS        = 2;
  localparam int MEM_WORDS = 256;
  localparam int AW        = 8;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  logic          clk;
  logic          nrst;
  logic          ren;
  logic [31:0]   addr;
  logic          valid;
  logic [31:0]   din;
  logic          err;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          busy;
  logic          ovf;

  // Second instance with zero wait states for the minimum-latency case.
  logic          ren0;
  logic [31:0]   addr0;
  logic          valid0;
  logic [31:0]   din0;
  logic          err0;
  logic          mem_en0;
  logic [AW-1:0] mem_addr0;
  logic [31:0]   mem_rdata0;
  logic          busy0;
  logic          ovf0;

  logic [31:0] mem [MEM_WORDS];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  logic [31:0]   q[$];
  resp_t         exp_resp[int];
  logic [AW-1:0] exp_mem[int];
  logic [31:0]   last_data;
  int            next_pop_ok;
  int            busy_until;
  logic          m_ovf;

  ext_ins_server #(.DEPTH(DEPTH), .WAIT_STATES(WS), .MEM_WORDS(MEM_WORDS), .AW(AW)) u_dut (
    .clk(clk), .nrst(nrst), .exIns_ren(ren), .exIns_addr(addr),
    .exIns_valid(valid), .exIns_in(din), .exIns_err(err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .overflow(ovf)
  );

  ext_ins_server #(.DEPTH(DEPTH), .WAIT_STATES(0), .MEM_WORDS(MEM_WORDS), .AW(AW)) u_dut0 (
    .clk(clk), .nrst(nrst), .exIns_ren(ren0), .exIns_addr(addr0),
    .exIns_valid(valid0), .exIns_in(din0), .exIns_err(err0),
    .mem_en(mem_en0), .mem_addr(mem_addr0), .mem_rdata(mem_rdata0),
    .busy(busy0), .overflow(ovf0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous backing memory: data the cycle after the enable.
  always @(posedge clk) begin
    if (mem_en)  mem_rdata  <= mem[mem_addr];
    if (mem_en0) mem_rdata0 <= mem[mem_addr0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_resp.delete();
    exp_mem.delete();
    last_data   = 32'h0;
    next_pop_ok = 0;
    busy_until  = 0;
    m_ovf       = 1'b0;
  endtask

  function automatic bit pop_due();
    return (q.size() > 0) && (cyc >= next_pop_ok);
  endfunction

  // Compare every observable output for the current cycle with the model.
  task automatic check_cycle();
    bit exp_v;
    bit exp_me;
    exp_v  = exp_resp.exists(cyc);
    exp_me = exp_mem.exists(cyc);
    check("valid", 32'(valid), 32'(exp_v));
    if (exp_v) begin
      last_data = exp_resp[cyc].data;
      check("err", 32'(err), 32'(exp_resp[cyc].err));
    end else begin
      check("err_idle", 32'(err), 32'h0);
    end
    check("data", din, last_data);
    check("mem_en", 32'(mem_en), 32'(exp_me));
    if (exp_me) check("mem_addr", 32'(mem_addr), 32'(exp_mem[cyc]));
    check("busy", 32'(busy), 32'((q.size() > 0) || (cyc < busy_until)));
    check("overflow", 32'(ovf), 32'(m_ovf));
  endtask

  // Service timing from the rules: pop in cycle s, good response at
  // s+3+WS with the memory read two cycles earlier, bad response at s+2,
  // next pop no earlier than the cycle after a response.
  task automatic model_step(input bit r, input logic [31:0] a);
    logic [31:0] h;
    int v;
    if (pop_due()) begin
      h = q.pop_front();
      if (h[1:0] != 2'b00 || (h >> 2) >= MEM_WORDS) begin
        v = cyc + 2;
        exp_resp[v] = '{data: 32'h0000_0013, err: 1'b1};
      end else begin
        v = cyc + 3 + WS;
        exp_mem[v-2] = h[AW+1:2];
        exp_resp[v]  = '{data: mem[h >> 2], err: 1'b0};
      end
      next_pop_ok = v + 1;
      busy_until  = v;
    end
    if (r) begin
      if (q.size() < DEPTH) q.push_back(a);
      else                  m_ovf = 1'b1;
    end
  endtask

  // Called at a falling edge: check this cycle, drive inputs, advance.
  task automatic step(input bit r, input logic [31:0] a);
    check_cycle();
    ren  = r;
    addr = a;
    if (nrst) model_step(r, a);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  initial begin
    int c0;
    int sel;
    logic [31:0] ra;

    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    mem[5] = 32'h00A0_0093;
    nrst = 1'b0; ren = 1'b0; addr = '0; ren0 = 1'b0; addr0 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    nrst = 1'b1;

    // Single good request to word 5
    idle(10);
    step(1'b1, 32'h14);
    idle(10);

    // Misaligned and out-of-range requests
    step(1'b1, 32'h16);
    step(1'b1, 32'h400);
    idle(10);

    // Fill the FIFO, then push exactly when an entry is popped
    for (int i = 0; i < 5; i++) step(1'b1, 32'h40 + 32'(4*i));
    for (int i = 0; i < 20; i++) begin
      if (pop_due()) begin
        step(1'b1, 32'h80);
        break;
      end
      step(1'b0, 32'h0);
    end
    idle(40);
    check("ovf_after_full_swap", 32'(ovf), 32'h0);

    // Six back-to-back requests: sixth dropped
    for (int i = 0; i < 6; i++) step(1'b1, 32'(4*i));
    idle(40);
    check("ovf_after_burst", 32'(ovf), 32'h1);

    // Reset during WAIT with two requests still queued
    step(1'b1, 32'h10);
    step(1'b1, 32'h20);
    step(1'b1, 32'h30);
    nrst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_data", din, 32'h0);
    check("mid_rst_mem_en", 32'(mem_en), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_ovf", 32'(ovf), 32'h0);
    model_reset();
    @(negedge clk);
    cyc++;
    idle(2);
    nrst = 1'b1;
    idle(20);

    // Zero wait states: mem_en two cycles after ren, response four after
    c0 = cyc;
    ren0 = 1'b1; addr0 = 32'h0;
    step(1'b0, 32'h0);
    ren0 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      check("ws0_mem_en", 32'(mem_en0), 32'(k == 2));
      if (k == 2) check("ws0_mem_addr", 32'(mem_addr0), 32'h0);
      check("ws0_valid", 32'(valid0), 32'(k == 4));
      if (k == 4) begin
        check("ws0_data", din0, mem[0]);
        check("ws0_err", 32'(err0), 32'h0);
      end
      step(1'b0, 32'h0);
    end
    check("ws0_latency_span", 32'(cyc - c0), 32'd7);
    check("ws0_busy", 32'(busy0), 32'h0);
    check("ws0_ovf", 32'(ovf0), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      ra = 32'($urandom_range(0, MEM_WORDS-1)) << 2;
      else if (sel == 7) ra = (32'($urandom_range(0, MEM_WORDS-1)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 8) ra = 32'($urandom_range(MEM_WORDS, 32'h3FFF_FFFF)) << 2;
      else               ra = 32'(MEM_WORDS-1) << 2;
      step($urandom_range(0, 2) == 0, ra);
    end
    idle(60);
    check("drained_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
